// File: rtl/key_pkg.sv
// Shared constants and types for the push-button debounce block.
// Keys are active-low: 0 means pressed, 1 means idle.
package key_pkg;

  localparam int DEBOUNCE_CYC_DEFAULT = 1_000_000;
  localparam int DEBOUNCE_CYC_SIM     = 10;

  localparam logic KEY_PRESSED  = 1'b0;
  localparam logic KEY_RELEASED = 1'b1;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_FILTER = 1'b1
  } state_e;

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, stability filter
// and registered press/release pulses for a single key.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic key,
  output logic key_stable,
  output logic key_press,
  output logic key_release
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             s1_q, s2_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;

  // Bring the asynchronous key level into the sys_clk domain.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      s1_q <= KEY_RELEASED;
      s2_q <= KEY_RELEASED;
    end else begin
      s1_q <= key;
      s2_q <= s1_q;
    end
  end

  // Accept a new level only after it held for DEBOUNCE_CYC samples.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    unique case (state_q)
      ST_STABLE: begin
        cnt_d = '0;
        if (s2_q != stable_q) begin
          state_d = ST_FILTER;
          cnt_d   = CNT_ONE;
        end
      end
      ST_FILTER: begin
        if (s2_q == stable_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ST_STABLE;
          cnt_d    = '0;
          stable_d = s2_q;
          press_d  = (s2_q == KEY_PRESSED);
          rel_d    = (s2_q == KEY_RELEASED);
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  // Filter state, counter, debounced level and pulse registers.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q  <= ST_STABLE;
      cnt_q    <= '0;
      stable_q <= KEY_RELEASED;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
    end
  end

  assign key_stable  = stable_q;
  assign key_press   = press_q;
  assign key_release = rel_q;

endmodule

// File: rtl/key_debounce.sv
// Multi-key debounce front end: one independent channel
// per raw push-button input.
module key_debounce
  import key_pkg::*;
#(
  parameter int KEY_W        = 2,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key,
  output logic [KEY_W-1:0] key_stable,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release
);

  for (genvar i = 0; i < KEY_W; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_ch (
      .sys_clk    (sys_clk),
      .rst        (rst),
      .key        (key[i]),
      .key_stable (key_stable[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed table plus random key
// activity checked against a sample-history reference model.
module tb_key_debounce;
  import key_pkg::*;

  localparam int KW  = 2;
  localparam int DEB = DEBOUNCE_CYC_SIM;

  logic          sys_clk = 1'b0;
  logic          rst;
  logic [KW-1:0] key;
  logic [KW-1:0] key_stable;
  logic [KW-1:0] key_press;
  logic [KW-1:0] key_release;

  key_debounce #(
    .KEY_W       (KW),
    .DEBOUNCE_CYC(DEB)
  ) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .key        (key),
    .key_stable (key_stable),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk  = 0;
  int n_fail = 0;

  // History of what was applied at every clock edge.
  logic [KW-1:0] kq[$];
  bit            rq[$];

  logic [KW-1:0] m_st, m_pr, m_rl;

  typedef struct {
    bit          r;
    logic [KW-1:0] k;
    int          n;
    logic [KW-1:0] es;
    logic [KW-1:0] ep;
    logic [KW-1:0] er;
  } vec_t;

  vec_t tbl[$];

  // Level the filter observes at edge e: raw key two edges
  // earlier, or idle if a reset sat in that path.
  function automatic logic seen(int e, int ch);
    logic [KW-1:0] v;
    if (e < 2) return 1'b1;
    if (rq[e-1] || rq[e-2]) return 1'b1;
    v = kq[e-2];
    return v[ch];
  endfunction

  // Flip a channel once its last DEB observed samples all
  // differ from the accepted level with no reset among them.
  task automatic model_edge(bit r, logic [KW-1:0] k);
    int  n;
    bit  ok;
    kq.push_back(k);
    rq.push_back(r);
    n    = kq.size() - 1;
    m_pr = '0;
    m_rl = '0;
    if (r) begin
      m_st = '1;
    end else begin
      for (int ch = 0; ch < KW; ch++) begin
        ok = (n >= DEB - 1);
        if (ok) begin
          for (int j = 0; j < DEB; j++) begin
            if (rq[n-j]) ok = 0;
            else if (seen(n - j, ch) == m_st[ch]) ok = 0;
          end
        end
        if (ok) begin
          m_st[ch] = ~m_st[ch];
          if (m_st[ch] == KEY_PRESSED) m_pr[ch] = 1'b1;
          else                         m_rl[ch] = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(string nm, logic [KW-1:0] got,
                     logic [KW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%b want=%b",
               nm, $time, got, exp);
    end
  endtask

  task automatic cyc(bit r, logic [KW-1:0] k);
    rst = r;
    key = k;
    @(posedge sys_clk);
    model_edge(r, k);
    #1;
    chk("model_stable", key_stable, m_st);
    chk("model_press", key_press, m_pr);
    chk("model_release", key_release, m_rl);
    chk("press_rel_excl", key_press & key_release, '0);
  endtask

  initial begin
    // reset hold, then both keys already pressed
    tbl.push_back('{1'b1, 2'b00, 5, 2'b11, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b00, 11, 2'b11, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b00, 1, 2'b00, 2'b11, 2'b00});
    tbl.push_back('{1'b0, 2'b00, 1, 2'b00, 2'b00, 2'b00});
    // release both
    tbl.push_back('{1'b0, 2'b11, 11, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b11, 1, 2'b11, 2'b00, 2'b11});
    tbl.push_back('{1'b0, 2'b11, 5, 2'b11, 2'b00, 2'b00});
    // clean press on key 0
    tbl.push_back('{1'b0, 2'b10, 11, 2'b11, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b10, 1, 2'b10, 2'b01, 2'b00});
    tbl.push_back('{1'b0, 2'b10, 1, 2'b10, 2'b00, 2'b00});
    // key 1 bounces 5 low / 3 high / 4 low
    tbl.push_back('{1'b0, 2'b00, 5, 2'b10, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b10, 3, 2'b10, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b00, 4, 2'b10, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b10, 15, 2'b10, 2'b00, 2'b00});
    // release key 0
    tbl.push_back('{1'b0, 2'b11, 11, 2'b10, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b11, 1, 2'b11, 2'b00, 2'b01});
    tbl.push_back('{1'b0, 2'b11, 3, 2'b11, 2'b00, 2'b00});
    // key 0 chatters, then settles low
    tbl.push_back('{1'b0, 2'b10, 2, 2'b11, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b11, 2, 2'b11, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b10, 3, 2'b11, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b11, 1, 2'b11, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b10, 11, 2'b11, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b10, 1, 2'b10, 2'b01, 2'b00});
    // long hold: no repeat, then one release
    tbl.push_back('{1'b0, 2'b10, 50, 2'b10, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b11, 11, 2'b10, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b11, 1, 2'b11, 2'b00, 2'b01});
    // key 1 low, reset at filter count 6
    tbl.push_back('{1'b0, 2'b01, 8, 2'b11, 2'b00, 2'b00});
    tbl.push_back('{1'b1, 2'b01, 1, 2'b11, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b01, 11, 2'b11, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b01, 1, 2'b01, 2'b10, 2'b00});
    tbl.push_back('{1'b0, 2'b01, 2, 2'b01, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b11, 11, 2'b01, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b11, 1, 2'b11, 2'b00, 2'b10});
    // reset while pressed gives no release pulse
    tbl.push_back('{1'b0, 2'b00, 11, 2'b11, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b00, 1, 2'b00, 2'b11, 2'b00});
    tbl.push_back('{1'b1, 2'b00, 1, 2'b11, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b11, 3, 2'b11, 2'b00, 2'b00});

    for (int i = 0; i < tbl.size(); i++) begin
      for (int c = 0; c < tbl[i].n; c++)
        cyc(tbl[i].r, tbl[i].k);
      chk($sformatf("vec%0d_stable", i), key_stable, tbl[i].es);
      chk($sformatf("vec%0d_press", i), key_press, tbl[i].ep);
      chk($sformatf("vec%0d_release", i), key_release, tbl[i].er);
    end

    // random key activity with occasional resets
    for (int it = 0; it < 300; it++) begin
      logic [KW-1:0] k;
      int            n;
      k = KW'($urandom_range(0, 3));
      n = int'($urandom_range(1, 14));
      if ($urandom_range(0, 19) == 0) cyc(1'b1, k);
      for (int c = 0; c < n; c++) cyc(1'b0, k);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
